// File: rtl/instr_fetch_queue.sv
// rtl/instr_fetch_queue.sv - PC owner, ROM address driver and prefetch FIFO feeding decode
// Redirect flushes the FIFO and restarts fetch; an out-of-range PC halts fetch until redirect.
module instr_fetch_queue #(
  parameter int                 ADDR_W    = 16,
  parameter int                 INSTR_W   = 16,
  parameter int                 DEPTH     = 4,
  parameter int                 MEM_BYTES = 1024,
  parameter logic [ADDR_W-1:0]  RESET_PC  = 16'h0000
) (
  input  logic               clk,
  input  logic               reset,
  output logic [ADDR_W-1:0]  imem_addr,
  input  logic [INSTR_W-1:0] imem_instr,
  input  logic               redirect_valid,
  input  logic [ADDR_W-1:0]  redirect_pc,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [INSTR_W-1:0] out_instr,
  output logic [ADDR_W-1:0]  out_pc,
  output logic               fetch_halted
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam logic [ADDR_W:0]  MEM_LIMIT = (ADDR_W+1)'(MEM_BYTES);
  localparam logic [PTR_W:0]   FULL_CNT  = (PTR_W+1)'(DEPTH);

  typedef enum logic {RUN, HALT} state_t;

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   pc_q, pc_d;
  logic [PTR_W:0]      count_q, count_d;
  logic [PTR_W-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]    rd_ptr_q, rd_ptr_d;
  logic [INSTR_W-1:0]  instr_mem_q [DEPTH];
  logic [INSTR_W-1:0]  instr_mem_d [DEPTH];
  logic [ADDR_W-1:0]   pc_mem_q [DEPTH];
  logic [ADDR_W-1:0]   pc_mem_d [DEPTH];

  logic in_range;
  logic full;
  logic pop;
  logic push;

  // Widened by one bit so a PC near the top of the address space cannot wrap into range.
  assign in_range = ({1'b0, pc_q} + (ADDR_W+1)'(3)) < MEM_LIMIT;
  assign full     = (count_q == FULL_CNT);
  assign pop      = (count_q != '0) && out_ready;
  assign push     = (state_q == RUN) && in_range && (!full || pop);

  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    count_d     = count_q;
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    instr_mem_d = instr_mem_q;
    pc_mem_d    = pc_mem_q;
    if (redirect_valid) begin
      count_d  = '0;
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      pc_d     = redirect_pc & ~(ADDR_W'(3));
      state_d  = RUN;
    end else begin
      if (state_q == RUN && !in_range) begin
        state_d = HALT;
      end
      if (push) begin
        instr_mem_d[wr_ptr_q] = imem_instr;
        pc_mem_d[wr_ptr_q]    = pc_q;
        wr_ptr_d              = wr_ptr_q + 1'b1;
        pc_d                  = pc_q + ADDR_W'(4);
      end
      if (pop) begin
        rd_ptr_d = rd_ptr_q + 1'b1;
      end
      count_d = count_q + (PTR_W+1)'(push) - (PTR_W+1)'(pop);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= RUN;
      pc_q     <= RESET_PC;
      count_q  <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        instr_mem_q[i] <= '0;
        pc_mem_q[i]    <= '0;
      end
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      count_q     <= count_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      instr_mem_q <= instr_mem_d;
      pc_mem_q    <= pc_mem_d;
    end
  end

  assign imem_addr    = pc_q;
  assign out_valid    = (count_q != '0);
  assign out_instr    = instr_mem_q[rd_ptr_q];
  assign out_pc       = pc_mem_q[rd_ptr_q];
  assign fetch_halted = (state_q == HALT);

endmodule

// File: tb/tb_instr_fetch_queue.sv
// tb/tb_instr_fetch_queue.sv - directed vector bench for instr_fetch_queue
module tb_instr_fetch_queue;

  logic        clk = 1'b0;
  logic        reset;
  logic [15:0] imem_addr;
  logic [15:0] imem_instr;
  logic        redirect_valid;
  logic [15:0] redirect_pc;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] out_instr;
  logic [15:0] out_pc;
  logic        fetch_halted;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  // ROM model: each 4-byte row holds a tag plus its row number.
  function automatic logic [15:0] rom(input logic [15:0] a);
    return 16'hC000 + {2'b00, a[15:2]};
  endfunction

  assign imem_instr = rom(imem_addr);

  instr_fetch_queue dut (
    .clk            (clk),
    .reset          (reset),
    .imem_addr      (imem_addr),
    .imem_instr     (imem_instr),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_instr      (out_instr),
    .out_pc         (out_pc),
    .fetch_halted   (fetch_halted)
  );

  typedef struct {
    logic        rst;
    logic        rdy;
    logic        ev;
    logic [15:0] epc;
    logic        chk_instr;
    logic [15:0] einstr;
    logic [15:0] eaddr;
  } vec_t;

  vec_t vecs [22];

  function automatic vec_t mk(input logic rst, input logic rdy, input logic ev,
                              input logic [15:0] epc, input logic ci,
                              input logic [15:0] ei, input logic [15:0] ea);
    vec_t v;
    v.rst = rst; v.rdy = rdy; v.ev = ev; v.epc = epc;
    v.chk_instr = ci; v.einstr = ei; v.eaddr = ea;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    // reset, stream, reset mid-stream, then backpressure from an empty FIFO
    vecs[0]  = mk(1, 1, 0, 16'd0,  1, 16'h0000, 16'd0);
    vecs[1]  = mk(1, 1, 0, 16'd0,  1, 16'h0000, 16'd0);
    vecs[2]  = mk(0, 1, 1, 16'd0,  1, 16'hC000, 16'd4);
    vecs[3]  = mk(0, 1, 1, 16'd4,  1, 16'hC001, 16'd8);
    vecs[4]  = mk(0, 1, 1, 16'd8,  1, 16'hC002, 16'd12);
    vecs[5]  = mk(0, 1, 1, 16'd12, 1, 16'hC003, 16'd16);
    vecs[6]  = mk(1, 1, 0, 16'd0,  1, 16'h0000, 16'd0);
    vecs[7]  = mk(0, 0, 1, 16'd0,  1, 16'hC000, 16'd4);
    vecs[8]  = mk(0, 0, 1, 16'd0,  1, 16'hC000, 16'd8);
    vecs[9]  = mk(0, 0, 1, 16'd0,  1, 16'hC000, 16'd12);
    vecs[10] = mk(0, 0, 1, 16'd0,  1, 16'hC000, 16'd16);
    for (int i = 11; i <= 16; i++) vecs[i] = mk(0, 0, 1, 16'd0, 1, 16'hC000, 16'd16);
    vecs[17] = mk(0, 1, 1, 16'd4,  1, 16'hC001, 16'd20);
    vecs[18] = mk(0, 1, 1, 16'd8,  1, 16'hC002, 16'd24);
    vecs[19] = mk(0, 1, 1, 16'd12, 1, 16'hC003, 16'd28);
    vecs[20] = mk(0, 1, 1, 16'd16, 1, 16'hC004, 16'd32);
    vecs[21] = mk(0, 1, 1, 16'd20, 1, 16'hC005, 16'd36);

    reset = 1'b1; redirect_valid = 1'b0; redirect_pc = 16'h0; out_ready = 1'b1;
    for (int i = 0; i < 22; i++) begin
      reset = vecs[i].rst;
      out_ready = vecs[i].rdy;
      step();
      chk($sformatf("v%0d out_valid", i), {31'd0, out_valid}, {31'd0, vecs[i].ev});
      if (vecs[i].ev || vecs[i].rst) begin
        chk($sformatf("v%0d out_pc", i), {16'd0, out_pc}, {16'd0, vecs[i].epc});
        if (vecs[i].chk_instr)
          chk($sformatf("v%0d out_instr", i), {16'd0, out_instr}, {16'd0, vecs[i].einstr});
      end
      chk($sformatf("v%0d imem_addr", i), {16'd0, imem_addr}, {16'd0, vecs[i].eaddr});
      chk($sformatf("v%0d halted", i), {31'd0, fetch_halted}, 32'd0);
    end

    // redirect while full with a simultaneous pop
    redirect_valid = 1'b1; redirect_pc = 16'h0102; out_ready = 1'b1;
    step();
    chk("redir out_valid", {31'd0, out_valid}, 32'd0);
    chk("redir imem_addr", {16'd0, imem_addr}, 32'h0100);
    redirect_valid = 1'b0;
    step();
    chk("redir+2 out_valid", {31'd0, out_valid}, 32'd1);
    chk("redir+2 out_pc", {16'd0, out_pc}, 32'h0100);
    chk("redir+2 out_instr", {16'd0, out_instr}, 32'hC040);

    // end of memory
    redirect_valid = 1'b1; redirect_pc = 16'd1016;
    step();
    redirect_valid = 1'b0;
    chk("eom addr", {16'd0, imem_addr}, 32'd1016);
    step();
    chk("eom 1016 valid", {31'd0, out_valid}, 32'd1);
    chk("eom 1016 pc", {16'd0, out_pc}, 32'd1016);
    step();
    chk("eom 1020 pc", {16'd0, out_pc}, 32'd1020);
    chk("eom 1020 instr", {16'd0, out_instr}, 32'hC0FF);
    chk("eom addr 1024", {16'd0, imem_addr}, 32'd1024);
    chk("eom not yet halted", {31'd0, fetch_halted}, 32'd0);
    for (int i = 0; i < 20; i++) begin
      step();
      chk($sformatf("eom hold%0d valid", i), {31'd0, out_valid}, 32'd0);
      chk($sformatf("eom hold%0d halted", i), {31'd0, fetch_halted}, 32'd1);
      chk($sformatf("eom hold%0d addr", i), {16'd0, imem_addr}, 32'd1024);
    end
    redirect_valid = 1'b1; redirect_pc = 16'd0;
    step();
    redirect_valid = 1'b0;
    chk("unhalt halted", {31'd0, fetch_halted}, 32'd0);
    chk("unhalt addr", {16'd0, imem_addr}, 32'd0);
    step();
    chk("unhalt out_pc", {16'd0, out_pc}, 32'd0);
    chk("unhalt valid", {31'd0, out_valid}, 32'd1);

    // out-of-range redirect target
    redirect_valid = 1'b1; redirect_pc = 16'hFFFC;
    step();
    redirect_valid = 1'b0;
    chk("oor+1 halted", {31'd0, fetch_halted}, 32'd0);
    chk("oor+1 addr", {16'd0, imem_addr}, 32'hFFFC);
    chk("oor+1 valid", {31'd0, out_valid}, 32'd0);
    step();
    chk("oor+2 halted", {31'd0, fetch_halted}, 32'd1);
    for (int i = 0; i < 3; i++) begin
      step();
      chk($sformatf("oor hold%0d valid", i), {31'd0, out_valid}, 32'd0);
      chk($sformatf("oor hold%0d addr", i), {16'd0, imem_addr}, 32'hFFFC);
    end

    // reset with three entries queued and a redirect presented
    redirect_valid = 1'b1; redirect_pc = 16'd0; out_ready = 1'b0;
    step();
    redirect_valid = 1'b0;
    step(); step(); step();
    chk("pre-reset addr", {16'd0, imem_addr}, 32'd12);
    reset = 1'b1; redirect_valid = 1'b1; redirect_pc = 16'h0200; out_ready = 1'b1;
    step();
    chk("rst valid", {31'd0, out_valid}, 32'd0);
    chk("rst addr", {16'd0, imem_addr}, 32'd0);
    chk("rst out_pc", {16'd0, out_pc}, 32'd0);
    chk("rst out_instr", {16'd0, out_instr}, 32'd0);
    chk("rst halted", {31'd0, fetch_halted}, 32'd0);
    reset = 1'b0; redirect_valid = 1'b0;
    step();
    chk("post-rst out_pc", {16'd0, out_pc}, 32'd0);
    chk("post-rst addr", {16'd0, imem_addr}, 32'd4);
    step();
    chk("post-rst next pc", {16'd0, out_pc}, 32'd4);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
